// File: rtl/pipeline_event_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_event_monitor_pkg
// Description : Shared types and constants for the pipeline event monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_event_monitor_pkg;

   // Measurement-run state machine encoding
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Read-select index of the cycle counter; event channel k sits at k+1
   localparam int RD_SEL_CYCLE = 0;

   // Conventional event bit positions on event_i / inhibit_i
   localparam int EV_STALL = 0;
   localparam int EV_FLUSH = 1;

endpackage
`default_nettype wire

// File: rtl/event_channel_counter.sv
`default_nettype none
// ============================================================================
// Module      : event_channel_counter
// Description : One monitor channel: qualifier / edge detect, saturating
//               counter, sticky overflow flag and snapshot shadow register.
// Revision    : 1.0 - initial release
// ============================================================================
module event_channel_counter #(
   parameter int CNT_WIDTH = 32,
   parameter bit EDGE_MODE = 1'b0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clear_i,
   input  logic                 count_en_i,
   input  logic                 event_i,
   input  logic                 inhibit_i,
   input  logic                 snap_i,
   output logic [CNT_WIDTH-1:0] count_o,
   output logic [CNT_WIDTH-1:0] shadow_o,
   output logic                 overflow_o
);

   logic                 prev_q, prev_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic [CNT_WIDTH-1:0] shadow_q, shadow_d;
   logic                 overflow_q, overflow_d;
   logic                 w_qual;
   logic                 w_hit;

   // Edge mode only sees a rising transition; prev tracks the raw strobe in
   // every state so a strobe already high at start does not look like an edge.
   assign w_qual = EDGE_MODE ? (event_i & ~prev_q) : event_i;
   assign w_hit  = count_en_i & ~inhibit_i & w_qual;

   // Next-state: clear wins over counting; snapshot takes the pre-update value
   always_comb begin
      prev_d     = event_i;
      count_d    = count_q;
      overflow_d = overflow_q;
      shadow_d   = shadow_q;
      if (clear_i) begin
         count_d    = '0;
         overflow_d = 1'b0;
      end else if (w_hit) begin
         if (&count_q) overflow_d = 1'b1;
         else          count_d    = count_q + CNT_WIDTH'(1);
      end
      // A coincident snapshot preserves the pre-clear values
      if (snap_i)       shadow_d = count_q;
      else if (clear_i) shadow_d = '0;
   end

   // Channel state registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prev_q     <= 1'b0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         shadow_q   <= '0;
      end else begin
         prev_q     <= prev_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         shadow_q   <= shadow_d;
      end
   end

   assign count_o    = count_q;
   assign shadow_o   = shadow_q;
   assign overflow_o = overflow_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_event_monitor.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_event_monitor
// Description : Performance monitor counting run cycles and qualified pipeline
//               events, with atomic snapshot and a registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_event_monitor
   import pipeline_event_monitor_pkg::*;
#(
   parameter int                    NUM_EVENTS = 2,
   parameter int                    CNT_WIDTH  = 32,
   parameter int                    MAX_CYCLES = 30,
   parameter logic [NUM_EVENTS-1:0] EDGE_MASK  = '0,
   localparam int                   SEL_W      = $clog2(NUM_EVENTS + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic                  clear_i,
   input  logic                  freeze_i,
   input  logic [NUM_EVENTS-1:0] event_i,
   input  logic [NUM_EVENTS-1:0] inhibit_i,
   input  logic                  snap_i,
   input  logic [SEL_W-1:0]      rd_sel_i,
   output logic [CNT_WIDTH-1:0]  rd_data_o,
   output logic [NUM_EVENTS:0]   overflow_o,
   output logic                  running_o,
   output logic                  done_o
);

   // Cycle count one below the terminal value: reaching it while counting
   // means this edge makes the counter equal MAX_CYCLES.
   localparam logic [CNT_WIDTH-1:0] C_LAST    = CNT_WIDTH'(MAX_CYCLES - 1);
   localparam bit                   C_LIMITED = (MAX_CYCLES != 0);

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                 w_count_en;
   logic                 w_reach_last;
   logic [CNT_WIDTH-1:0] w_cycle_cnt;
   logic [CNT_WIDTH-1:0] w_shadow [NUM_EVENTS+1];
   logic [NUM_EVENTS:0]  w_ovf;

   assign w_count_en   = (state_q == ST_RUN) && !freeze_i;
   assign w_reach_last = C_LIMITED && w_count_en && (w_cycle_cnt == C_LAST);

   // Cycle counter: a channel whose qualifier is permanently true
   event_channel_counter #(
      .CNT_WIDTH (CNT_WIDTH),
      .EDGE_MODE (1'b0)
   ) u_cycle (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear_i    (clear_i),
      .count_en_i (w_count_en),
      .event_i    (1'b1),
      .inhibit_i  (1'b0),
      .snap_i     (snap_i),
      .count_o    (w_cycle_cnt),
      .shadow_o   (w_shadow[RD_SEL_CYCLE]),
      .overflow_o (w_ovf[RD_SEL_CYCLE])
   );

   for (genvar k = 0; k < NUM_EVENTS; k++) begin : g_event
      logic [CNT_WIDTH-1:0] w_unused_live;
      event_channel_counter #(
         .CNT_WIDTH (CNT_WIDTH),
         .EDGE_MODE (EDGE_MASK[k])
      ) u_chan (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .clear_i    (clear_i),
         .count_en_i (w_count_en),
         .event_i    (event_i[k]),
         .inhibit_i  (inhibit_i[k]),
         .snap_i     (snap_i),
         .count_o    (w_unused_live),
         .shadow_o   (w_shadow[k+1]),
         .overflow_o (w_ovf[k+1])
      );
   end

   // Run-control next state: clear beats start; start only acts from IDLE
   always_comb begin
      state_d = state_q;
      if (clear_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (start_i)      state_d = ST_RUN;
            ST_RUN:  if (w_reach_last) state_d = ST_DONE;
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Shadow read mux; unused select codes read as zero
   always_comb begin
      rd_data_d = '0;
      for (int i = 0; i <= NUM_EVENTS; i++) begin
         if (rd_sel_i == SEL_W'(i)) rd_data_d = w_shadow[i];
      end
   end

   // State and read-port registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data_o  = rd_data_q;
   assign overflow_o = w_ovf;
   assign running_o  = (state_q == ST_RUN);
   assign done_o     = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: doc/pipeline_event_monitor.md
# pipeline_event_monitor

Synthesizable, parametrised performance monitor for the pipelined CPU. It counts run cycles and up to NUM_EVENTS qualified pipeline events, such as stall and flush, in hardware rather than in the bench. Each event channel supports a per-channel inhibit, level or rising-edge counting, saturation and sticky overflow. It sits beside the CPU top level, takes hazard-unit strobes as inputs, and exposes an atomic snapshot through a registered read port.

## Interface
- NUM_EVENTS, 2: number of event channels (1..15).
- CNT_WIDTH, 32: width of every counter (8..64).
- MAX_CYCLES, 30: run length in cycles; 0 = unlimited.
- EDGE_MASK, '0: bit k=1 makes channel k count rising edges; 0 counts levels.
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  begin a measurement run (IDLE only).
- clear_i  in  1  zero counters, overflow flags and shadows; return to IDLE.
- freeze_i  in  1  pause all counting while high in RUN.
- event_i  in  NUM_EVENTS  raw event strobes (bit 0 = stall, bit 1 = flush by convention).
- inhibit_i  in  NUM_EVENTS  per-channel qualifier; the event is ignored while its bit is high (e.g. stall during branch).
- snap_i  in  1  copy all live counters into the shadow registers.
- rd_sel_i  in  $clog2(NUM_EVENTS+1)  0 = cycle count, k = event channel k-1.
- rd_data_o  out  CNT_WIDTH  shadow value selected, registered.
- overflow_o  out  NUM_EVENTS+1  sticky saturation flags; bit 0 = cycle counter.
- running_o  out  1  state == RUN.
- done_o  out  1  state == DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start_i.
  - RUN -> DONE at the edge where the cycle counter becomes MAX_CYCLES (only when MAX_CYCLES != 0).
  - Any state -> IDLE on clear_i.
  - start_i in RUN or DONE is ignored.
- Cycle counter: increments on each RUN edge while freeze_i = 0. The first RUN edge after start gives count 1.
- Channel k counts at an edge when all of the following hold: state == RUN, freeze_i = 0, inhibit_i[k] = 0, and q[k] = 1.
  - Level mode: q[k] = event_i[k].
  - Edge mode: q[k] = event_i[k] & ~prev[k].
- prev[k] updates every cycle in every state, so an event high across start_i is not counted as an edge.
- Saturation: counters stop at all-ones. The matching overflow_o bit sets on the attempted increment past all-ones and stays set until clear_i or rst_i.
- DONE: all counters hold; snapshot and read still work.
- Snapshot: at the edge where snap_i = 1, the shadows take the live values held before that edge's update.
- Read: rd_data_o at edge e+1 = shadow[rd_sel_i sampled at edge e]. An out-of-range rd_sel_i yields 0.

## Timing
- Reset values: state IDLE; all counters, shadows, prev and overflow_o = 0; rd_data_o = 0; running_o = 0; done_o = 0.
- Priority: rst_i > clear_i > start_i. If clear_i and snap_i coincide, the shadows capture the pre-clear values and the live counters go to 0.
- Event-to-live-counter latency: 1 edge. Event-to-rd_data_o: snapshot edge plus one read edge.
- done_o rises on the same edge the cycle counter reaches MAX_CYCLES. Events sampled at that edge are still counted.
- freeze_i also blocks the transition to DONE, since the cycle counter does not advance.
- rst_i mid-run aborts the run immediately; no partial state is kept.

## Structure
- Package pipeline_event_monitor_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the RD_SEL_CYCLE = 0 constant;
  - the event-index constants EV_STALL = 0 and EV_FLUSH = 1.
- Sub-module event_channel_counter, instantiated once per event channel and once for the cycle counter (with q tied to 1). It contains:
  - qualify/edge-detect logic;
  - a saturating counter;
  - a sticky overflow flag;
  - a shadow register.
- The top level holds the FSM, the read mux and the output register.

## Test plan
- Reset, then start_i, with event_i = 2'b01 for 5 cycles and MAX_CYCLES = 30 -> after 30 edges done_o = 1, cycle = 30, stall = 5, flush = 0; snap plus rd_sel 0/1/2 reads 30/5/0.
- Stall high for 4 cycles with inhibit_i[0] high in 2 of them -> stall = 2.
- EDGE_MASK = 2'b10 with flush held high for 6 cycles, then 2 single pulses -> flush = 3. With flush already high at start_i, the count excludes that edge.
- CNT_WIDTH = 8, MAX_CYCLES = 0, stall constantly high for 300 cycles -> stall = 255, overflow_o[1] = 1 and overflow_o[0] = 1; clear_i -> all 0, IDLE.
- freeze_i high for 10 cycles mid-run -> cycle and event counts unchanged across the window; done_o delayed by 10 cycles.
- clear_i and snap_i on the same edge at cycle = 12 -> read of rd_sel 0 returns 12, live counter 0, state IDLE. rst_i mid-run -> all outputs return to their reset values next edge.
